lcd_char_sink: RTL

//  Receive-side model of the 4-bit character-LCD bus that the LCD driver produces (lcd_dataout, lcd_control).

---
 rtl/lcd_char_sink.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_char_sink.sv
// rtl/lcd_char_sink.sv - receive-side model of a 4-bit character-LCD bus with a 16x2 DDRAM image
//
// Ports:
//   clk_in       system clock
//   Clear        asynchronous active-high reset
//   lcd_data     LCD data nibble from the driver
//   lcd_control  {E, RS, RW} from the driver
//   rd_addr      image read index, [4]=line, [3:0]=column
//   rd_char      DDRAM image at rd_addr, registered (1-cycle latency)
//   byte_valid   one-cycle pulse per assembled byte
//   byte_out     last assembled byte (held)
//   byte_rs      RS of last assembled byte (held)
//   cursor_addr  DDRAM address counter
//   display_on   D bit of the last Display On/Off command
//   four_bit     set once 4-bit mode is entered
//   busy         high while the fill sweep runs
//   err_busy     sticky: a byte completed while busy and was dropped
module lcd_char_sink #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
    input  logic       clk_in,
    input  logic       Clear,
    input  logic [3:0] lcd_data,
    input  logic [2:0] lcd_control,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       four_bit,
    output logic       busy,
    output logic       err_busy
);

    typedef enum logic [1:0] {
        INIT8  = 2'd0,
        NIB_HI = 2'd1,
        NIB_LO = 2'd2
    } mode_t;

    // Bus sample layout: [6]=E, [5]=RS, [4]=RW, [3:0]=data
    logic [6:0] bus_in;
    logic [6:0] sync_q [SYNC_STAGES];
    logic [6:0] cur;
    logic [6:0] prev_q;
    logic       e_fall;
    logic       strobe;

    mode_t      state;
    mode_t      state_next;
    logic       byte_done;
    logic [7:0] byte_asm;
    logic       rs_asm;

    logic [3:0] hi_nib;
    logic       hi_rs;
    logic       exec_pending;
    logic       id_inc;
    logic [4:0] sweep_cnt;

    logic [7:0] mem [32];
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       addr_in_window;

    assign bus_in = {lcd_control, lcd_data};
    assign cur    = sync_q[SYNC_STAGES-1];

    // prev_q holds the synced sample of the cycle before cur, so on the
    // falling edge it still carries the data/RS/RW seen while E was high.
    assign e_fall = prev_q[6] & ~cur[6];
    assign strobe = e_fall & ~prev_q[4];

    always_ff @(posedge clk_in or posedge Clear) begin
        if (Clear) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= cur;
        end
    end

    // Mode FSM: state register
    always_ff @(posedge clk_in or posedge Clear) begin
        if (Clear) begin
            state <= INIT8;
        end else begin
            state <= state_next;
        end
    end

    // Mode FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            INIT8: begin
                if (strobe && !prev_q[5] && prev_q[3:0] == 4'h2) begin
                    state_next = NIB_HI;
                end
            end
            NIB_HI: begin
                if (strobe) begin
                    state_next = NIB_LO;
                end
            end
            NIB_LO: begin
                if (strobe) begin
                    state_next = NIB_HI;
                end
            end
            default: state_next = INIT8;
        endcase
    end

    // Mode FSM: outputs (byte completion and assembled value)
    always_comb begin
        byte_done = 1'b0;
        byte_asm  = 8'h00;
        rs_asm    = 1'b0;
        case (state)
            INIT8: begin
                byte_done = strobe;
                byte_asm  = {prev_q[3:0], 4'h0};
                rs_asm    = prev_q[5];
            end
            NIB_LO: begin
                byte_done = strobe;
                byte_asm  = {hi_nib, prev_q[3:0]};
                // RS of the high half wins if the halves disagree
                rs_asm    = hi_rs;
            end
            default: begin
                byte_done = 1'b0;
            end
        endcase
    end

    // Byte capture, drop-while-busy flagging, and execution scheduling.
    // 8-bit-mode ops during init carry no effect, so only 4-bit bytes are queued.
    always_ff @(posedge clk_in or posedge Clear) begin
        if (Clear) begin
            hi_nib       <= 4'h0;
            hi_rs        <= 1'b0;
            byte_valid   <= 1'b0;
            byte_out     <= 8'h00;
            byte_rs      <= 1'b0;
            err_busy     <= 1'b0;
            exec_pending <= 1'b0;
            four_bit     <= 1'b0;
        end else begin
            byte_valid   <= byte_done;
            exec_pending <= byte_done && !busy && (state != INIT8);
            if (state == NIB_HI && strobe) begin
                hi_nib <= prev_q[3:0];
                hi_rs  <= prev_q[5];
            end
            if (byte_done) begin
                byte_out <= byte_asm;
                byte_rs  <= rs_asm;
                if (busy) begin
                    err_busy <= 1'b1;
                end
            end
            if (state == INIT8 && state_next == NIB_HI) begin
                four_bit <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == 7'h0F)      n = 7'h40;
            else if (a == 7'h4F) n = 7'h00;
            else                 n = a + 7'd1;
        end else begin
            if (a == 7'h40)      n = 7'h0F;
            else if (a == 7'h00) n = 7'h4F;
            else                 n = a - 7'd1;
        end
        return n;
    endfunction

    assign addr_in_window = (cursor_addr[6:4] == 3'b000) || (cursor_addr[6:4] == 3'b100);

    // Command/data execution and the fill sweep. Reset starts a sweep so the
    // image is filled without needing a resettable memory array.
    always_ff @(posedge clk_in or posedge Clear) begin
        if (Clear) begin
            cursor_addr <= 7'h00;
            id_inc      <= 1'b1;
            display_on  <= 1'b0;
            busy        <= 1'b1;
            sweep_cnt   <= 5'd0;
        end else if (busy) begin
            sweep_cnt <= sweep_cnt + 5'd1;
            if (sweep_cnt == 5'd31) begin
                busy <= 1'b0;
            end
        end else if (exec_pending) begin
            if (byte_rs) begin
                cursor_addr <= next_addr(cursor_addr, id_inc);
            end else begin
                casez (byte_out)
                    8'b1???????: cursor_addr <= byte_out[6:0];
                    8'b00001???: display_on  <= byte_out[2];
                    8'b000001??: id_inc      <= byte_out[1];
                    8'b0000001?: cursor_addr <= 7'h00;
                    8'b00000001: begin
                        cursor_addr <= 7'h00;
                        id_inc      <= 1'b1;
                        busy        <= 1'b1;
                        sweep_cnt   <= 5'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Single write port: sweep has priority, data writes only inside the visible window
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = 5'd0;
        mem_wdata = 8'h00;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_cnt;
            mem_wdata = FILL_CHAR;
        end else if (exec_pending && byte_rs && addr_in_window) begin
            mem_we    = 1'b1;
            mem_waddr = {cursor_addr[6], cursor_addr[3:0]};
            mem_wdata = byte_out;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read; a same-cycle write to the same cell returns the old value
    always_ff @(posedge clk_in or posedge Clear) begin
        if (Clear) begin
            rd_char <= FILL_CHAR;
        end else begin
            rd_char <= mem[rd_addr];
        end
    end

endmodule
